// File: rtl/sec60_time_setter_if.sv
// ---------------------------------------------------------------------------
// sec60_time_setter_if
// Bundles the button inputs, the live counter digits and the load/edit
// outputs exchanged between the time-setter and the 60-second counter/display.
//   master : the time-setter (reads buttons + CUR_*, drives LOAD/LD_*/HOLD/
//            EDIT_SEL/BLINK)
//   slave  : the counter/display side and the button pads
// ---------------------------------------------------------------------------
interface sec60_time_setter_if;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic       BTN_DOWN;
  logic [3:0] CUR_SEC;
  logic [2:0] CUR_SEC10;
  logic       LOAD;
  logic [3:0] LD_SEC;
  logic [2:0] LD_SEC10;
  logic       HOLD;
  logic [1:0] EDIT_SEL;
  logic       BLINK;

  modport master (
    input  BTN_MODE, BTN_UP, BTN_DOWN, CUR_SEC, CUR_SEC10,
    output LOAD, LD_SEC, LD_SEC10, HOLD, EDIT_SEL, BLINK
  );

  modport slave (
    output BTN_MODE, BTN_UP, BTN_DOWN, CUR_SEC, CUR_SEC10,
    input  LOAD, LD_SEC, LD_SEC10, HOLD, EDIT_SEL, BLINK
  );
endinterface

// File: rtl/sec60_time_setter.sv
// ---------------------------------------------------------------------------
// sec60_time_setter
// Button front end and set-mode FSM for the 60-second counter. Three raw
// buttons are synchronised, debounced on a slow sample tick and turned into
// one-cycle press events. MODE walks RUN -> EDIT_SEC10 -> EDIT_SEC -> RUN;
// UP/DOWN edit the selected digit with wrap-around; leaving EDIT_SEC emits a
// one-cycle LOAD strobe carrying the edited digits.
// Ports:
//   CLK100 : system clock
//   RST    : synchronous, active-high reset
//   bus    : sec60_time_setter_if.master (BTN_*, CUR_* in; LOAD, LD_SEC,
//            LD_SEC10, HOLD, EDIT_SEL, BLINK out)
// Build option:
//   SEC60_AUTO_REPEAT_EN : when defined, holding UP or DOWN alone in an edit
//   state repeats the event after 500 ticks, then every 100 ticks.
// ---------------------------------------------------------------------------
module sec60_time_setter #(
  parameter int TICK_DIV    = 100_000,
  parameter int DB_SAMPLES  = 3,
  parameter int BLINK_TICKS = 250
) (
  input  logic                  CLK100,
  input  logic                  RST,
  sec60_time_setter_if.master   bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_SAMPLES + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_SAMPLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  // Encoding doubles as EDIT_SEL.
  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_EDIT_SEC10 = 2'b01,
    ST_EDIT_SEC   = 2'b10
  } state_t;

  // Button index: 0 = MODE, 1 = UP, 2 = DOWN.
  logic [2:0]    btn_raw;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    db_q, db_d, db_prev_q, db_prev_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [2:0]    ev_q, ev_d;
  state_t        state_q, state_d;
  logic [3:0]    ld_sec_q, ld_sec_d;
  logic [2:0]    ld_sec10_q, ld_sec10_d;
  logic          load_q, load_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          rpt_up, rpt_dn;
  logic          mode_ev, up_ev, dn_ev;

  assign btn_raw = {bus.BTN_DOWN, bus.BTN_UP, bus.BTN_MODE};

`ifdef SEC60_AUTO_REPEAT_EN
  logic [8:0] rpt_cnt_q, rpt_cnt_d;
  logic       rpt_armed_q, rpt_armed_d;
  logic       rpt_up_q, rpt_up_d, rpt_dn_q, rpt_dn_d;
  logic       rpt_hold;

  assign rpt_up = rpt_up_q;
  assign rpt_dn = rpt_dn_q;

  // Count ticks while exactly one of UP/DOWN is held in an edit state; the
  // first repeat needs 500 ticks, later ones 100.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_up_d    = 1'b0;
    rpt_dn_d    = 1'b0;
    rpt_hold    = (state_q != ST_RUN) && (db_q[1] ^ db_q[2]) && (state_d == state_q);
    if (!rpt_hold) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end else if (tick) begin
      if (rpt_cnt_q == (rpt_armed_q ? 9'd99 : 9'd499)) begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
        rpt_up_d    = db_q[1];
        rpt_dn_d    = db_q[2];
      end else begin
        rpt_cnt_d = rpt_cnt_q + 9'd1;
      end
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    db_d       = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_d[i]     = ~db_q[i];
            db_cnt_d[i] = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
    end
    // Press pulse lands the cycle after the debounced level rises.
    db_prev_d = db_q;
    ev_d      = db_q & ~db_prev_q;
  end

  // MODE wins; simultaneous UP and DOWN cancel.
  always_comb begin
    mode_ev = ev_q[0];
    up_ev   = (ev_q[1] | rpt_up) & ~(ev_q[2] | rpt_dn) & ~mode_ev;
    dn_ev   = (ev_q[2] | rpt_dn) & ~(ev_q[1] | rpt_up) & ~mode_ev;
  end

  always_comb begin
    state_d    = state_q;
    ld_sec_d   = ld_sec_q;
    ld_sec10_d = ld_sec10_q;
    load_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          state_d    = ST_EDIT_SEC10;
          ld_sec_d   = bus.CUR_SEC;
          ld_sec10_d = bus.CUR_SEC10;
        end
      end
      ST_EDIT_SEC10: begin
        // Out-of-range captured values fall to 0 on the first edit.
        if (mode_ev)    state_d = ST_EDIT_SEC;
        else if (up_ev) ld_sec10_d = (ld_sec10_q >= 3'd5) ? 3'd0 : ld_sec10_q + 3'd1;
        else if (dn_ev) ld_sec10_d = (ld_sec10_q > 3'd5) ? 3'd0 :
                                     (ld_sec10_q == 3'd0) ? 3'd5 : ld_sec10_q - 3'd1;
      end
      ST_EDIT_SEC: begin
        if (mode_ev) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end
        else if (up_ev) ld_sec_d = (ld_sec_q >= 4'd9) ? 4'd0 : ld_sec_q + 4'd1;
        else if (dn_ev) ld_sec_d = (ld_sec_q > 4'd9) ? 4'd0 :
                                   (ld_sec_q == 4'd0) ? 4'd9 : ld_sec_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Blink phase is held at 0 in RUN, so the counter starts fresh on every
  // entry to EDIT_SEC10.
  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (state_q == ST_RUN || state_d == ST_RUN) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      tick_cnt_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      ev_q        <= '0;
      state_q     <= ST_RUN;
      ld_sec_q    <= '0;
      ld_sec10_q  <= '0;
      load_q      <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
`ifdef SEC60_AUTO_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
      rpt_up_q    <= 1'b0;
      rpt_dn_q    <= 1'b0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      ev_q        <= ev_d;
      state_q     <= state_d;
      ld_sec_q    <= ld_sec_d;
      ld_sec10_q  <= ld_sec10_d;
      load_q      <= load_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
`ifdef SEC60_AUTO_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
      rpt_up_q    <= rpt_up_d;
      rpt_dn_q    <= rpt_dn_d;
`endif
    end
  end

  assign bus.LOAD     = load_q;
  assign bus.LD_SEC   = ld_sec_q;
  assign bus.LD_SEC10 = ld_sec10_q;
  assign bus.EDIT_SEL = state_q;
  assign bus.HOLD     = (state_q != ST_RUN);
  assign bus.BLINK    = blink_q;

endmodule

// File: tb/tb_sec60_time_setter.sv
// Scoreboard bench: every stimulus step that should move the outputs pushes
// the expected {LOAD,HOLD,EDIT_SEL,LD_SEC10,LD_SEC} tuple; the monitor pops one
// entry each time the observed tuple changes.
module tb_sec60_time_setter;
  logic CLK100 = 1'b0;
  logic RST    = 1'b1;
  always #5 CLK100 = ~CLK100;

  sec60_time_setter_if bus();

  sec60_time_setter #(.TICK_DIV(4), .DB_SAMPLES(3), .BLINK_TICKS(250)) dut (
    .CLK100 (CLK100),
    .RST    (RST),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [10:0] exp_q [$];
  logic        mon_en   = 1'b0;
  logic [10:0] prev;
  logic [10:0] mon_exp;
  wire  [10:0] obs = {bus.LOAD, bus.HOLD, bus.EDIT_SEL, bus.LD_SEC10, bus.LD_SEC};

  function automatic logic [10:0] tup(input logic l, input logic h, input logic [1:0] es,
                                      input logic [2:0] s10, input logic [3:0] s);
    return {l, h, es, s10, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(negedge CLK100) begin
    if (mon_en && (obs !== prev)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_change: got %0h, required no change from %0h", obs, prev);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard {load,hold,sel,sec10,sec}", {21'd0, obs}, {21'd0, mon_exp});
      end
      prev = obs;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK100);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic u, input logic d, input int hold_cyc);
    bus.BTN_MODE = m; bus.BTN_UP = u; bus.BTN_DOWN = d;
    cyc(hold_cyc);
    bus.BTN_MODE = 1'b0; bus.BTN_UP = 1'b0; bus.BTN_DOWN = 1'b0;
    cyc(40);
  endtask

  initial begin
    int loads;
    bus.BTN_MODE = 1'b0; bus.BTN_UP = 1'b0; bus.BTN_DOWN = 1'b0;
    bus.CUR_SEC = 4'd0; bus.CUR_SEC10 = 3'd0;
    RST = 1'b1;
    cyc(3);
    RST = 1'b0;
    @(negedge CLK100);
    check("rst_LOAD",     bus.LOAD,     0);
    check("rst_LD_SEC",   bus.LD_SEC,   0);
    check("rst_LD_SEC10", bus.LD_SEC10, 0);
    check("rst_HOLD",     bus.HOLD,     0);
    check("rst_EDIT_SEL", bus.EDIT_SEL, 0);
    check("rst_BLINK",    bus.BLINK,    0);
    prev   = obs;
    mon_en = 1'b1;

    // Idle: no LOAD over 10k cycles.
    loads = 0;
    repeat (10000) begin
      @(negedge CLK100);
      if (bus.LOAD) loads++;
    end
    check("idle_load_count", loads, 0);

    // UP in RUN is ignored (nothing pushed).
    press(1'b0, 1'b1, 1'b0, 40);

    // Bounce, then a clean hold: exactly one RUN->EDIT_SEC10 with capture.
    bus.CUR_SEC10 = 3'd4; bus.CUR_SEC = 4'd8;
    exp_q.push_back(tup(0, 1, 2'b01, 3'd4, 4'd8));
    for (int c = 0; c < 40; c++) begin
      bus.BTN_MODE = ((c / 3) % 2 == 0);
      cyc(1);
    end
    check("bounce_no_event", bus.EDIT_SEL, 0);
    press(1'b1, 1'b0, 1'b0, 60);

    // Tens wrap 4->5->0->1.
    exp_q.push_back(tup(0, 1, 2'b01, 3'd5, 4'd8)); press(1'b0, 1'b1, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b01, 3'd0, 4'd8)); press(1'b0, 1'b1, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b01, 3'd1, 4'd8)); press(1'b0, 1'b1, 1'b0, 40);
    // Seconds wrap 8->9->0.
    exp_q.push_back(tup(0, 1, 2'b10, 3'd1, 4'd8)); press(1'b1, 1'b0, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd1, 4'd9)); press(1'b0, 1'b1, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd1, 4'd0)); press(1'b0, 1'b1, 1'b0, 40);
    // Load strobe: one cycle, in RUN with HOLD low.
    exp_q.push_back(tup(1, 0, 2'b00, 3'd1, 4'd0));
    exp_q.push_back(tup(0, 0, 2'b00, 3'd1, 4'd0));
    press(1'b1, 1'b0, 1'b0, 40);

    // Priority: MODE+UP advances without editing; UP+DOWN cancel.
    bus.CUR_SEC10 = 3'd3; bus.CUR_SEC = 4'd7;
    exp_q.push_back(tup(0, 1, 2'b01, 3'd3, 4'd7)); press(1'b1, 1'b0, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd3, 4'd7)); press(1'b1, 1'b1, 1'b0, 40);
    press(1'b0, 1'b1, 1'b1, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd3, 4'd8)); press(1'b0, 1'b1, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd3, 4'd9)); press(1'b0, 1'b1, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd3, 4'd0)); press(1'b0, 1'b1, 1'b0, 40);
    // DOWN at 0 wraps to 9.
    exp_q.push_back(tup(0, 1, 2'b10, 3'd3, 4'd9)); press(1'b0, 1'b0, 1'b1, 40);

    // Reset mid-edit: back to RUN, LD_* cleared, no LOAD.
    exp_q.push_back(tup(0, 0, 2'b00, 3'd0, 4'd0));
    RST = 1'b1;
    cyc(3);
    RST = 1'b0;
    loads = 0;
    repeat (50) begin
      @(negedge CLK100);
      if (bus.LOAD) loads++;
    end
    check("rst_mid_edit_no_load", loads, 0);
    check("rst_mid_edit_sel", bus.EDIT_SEL, 0);

    // Out-of-range capture plus blink timing after entering EDIT_SEC10.
    bus.CUR_SEC10 = 3'd7; bus.CUR_SEC = 4'd12;
    exp_q.push_back(tup(0, 1, 2'b01, 3'd7, 4'd12)); press(1'b1, 1'b0, 1'b0, 40);
    check("blink_start", bus.BLINK, 0);
    cyc(1000);
    check("blink_first_toggle", bus.BLINK, 1);
    cyc(1000);
    check("blink_second_toggle", bus.BLINK, 0);
    exp_q.push_back(tup(0, 1, 2'b01, 3'd0, 4'd12)); press(1'b0, 1'b0, 1'b1, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd0, 4'd12)); press(1'b1, 1'b0, 1'b0, 40);
    exp_q.push_back(tup(0, 1, 2'b10, 3'd0, 4'd0));  press(1'b0, 1'b0, 1'b1, 40);

    // Long UP hold (~850 ticks).
`ifdef SEC60_AUTO_REPEAT_EN
    for (int k = 1; k <= 5; k++) exp_q.push_back(tup(0, 1, 2'b10, 3'd0, 4'(k)));
    press(1'b0, 1'b1, 1'b0, 3400);
    exp_q.push_back(tup(1, 0, 2'b00, 3'd0, 4'd5));
    exp_q.push_back(tup(0, 0, 2'b00, 3'd0, 4'd5));
`else
    exp_q.push_back(tup(0, 1, 2'b10, 3'd0, 4'd1));
    press(1'b0, 1'b1, 1'b0, 3400);
    exp_q.push_back(tup(1, 0, 2'b00, 3'd0, 4'd1));
    exp_q.push_back(tup(0, 0, 2'b00, 3'd0, 4'd1));
`endif
    press(1'b1, 1'b0, 1'b0, 40);
    check("blink_in_run", bus.BLINK, 0);

    cyc(100);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
